// File: rtl/string_match_engine_pkg.sv
// Shared FSM encoding and special character codes for the string match engine.
package string_match_engine_pkg;

  typedef enum logic [2:0] {IDLE, LOAD_STR, LOAD_PAT, SEARCH, DONE} sme_state_t;

  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_SPACE  = 8'h20;

endpackage

// File: rtl/string_match_engine_window_cmp.sv
// Combinational test of one candidate start position: literal/wildcard compare
// of every pattern slot in parallel plus the optional word-boundary anchors.
module sme_window_cmp
  import string_match_engine_pkg::*;
#(
  parameter int STR_DEPTH = 32,
  parameter int PAT_DEPTH = 8,
  parameter int CHAR_W    = 8,
  parameter int IDX_W     = $clog2(STR_DEPTH),
  parameter int LEN_W     = $clog2(STR_DEPTH + 1),
  parameter int PLEN_W    = $clog2(PAT_DEPTH + 1)
) (
  input  logic [STR_DEPTH-1:0][CHAR_W-1:0] str,
  input  logic [LEN_W-1:0]                 strlen,
  input  logic [PAT_DEPTH-1:0][CHAR_W-1:0] pat,
  input  logic [PLEN_W-1:0]                patlen,
  input  logic                             anchor_start,
  input  logic                             anchor_end,
  input  logic [LEN_W-1:0]                 pos,
  output logic                             hit
);

  logic [PAT_DEPTH-1:0] char_ok;
  logic [LEN_W-1:0]     pos_m1;
  logic [LEN_W-1:0]     end_pos;
  logic                 start_ok;
  logic                 end_ok;

  for (genvar gi = 0; gi < PAT_DEPTH; gi++) begin : g_char
    logic [LEN_W:0] idx;
    assign idx = {1'b0, pos} + (LEN_W + 1)'(gi);
    // Slots past the pattern length are don't-care.
    assign char_ok[gi] = (PLEN_W'(gi) >= patlen) ||
                         (pat[gi] == CHAR_W'(CH_DOT)) ||
                         ((idx < (LEN_W + 1)'(STR_DEPTH)) && (str[idx[IDX_W-1:0]] == pat[gi]));
  end

  assign pos_m1   = pos - LEN_W'(1);
  assign end_pos  = pos + LEN_W'(patlen);
  assign start_ok = (pos == '0) || (str[pos_m1[IDX_W-1:0]] == CHAR_W'(CH_SPACE));
  assign end_ok   = (end_pos == strlen) ||
                    ((end_pos < LEN_W'(STR_DEPTH)) && (str[end_pos[IDX_W-1:0]] == CHAR_W'(CH_SPACE)));

  assign hit = (&char_ok) && (!anchor_start || start_ok) && (!anchor_end || end_ok);

endmodule

// File: rtl/string_match_engine.sv
// Loads a string and a pattern ('^', '$', '.' supported) character by character,
// then scans one candidate start position per cycle for the lowest match.
module string_match_engine
  import string_match_engine_pkg::*;
#(
  parameter int STR_DEPTH = 32,
  parameter int PAT_DEPTH = 8,
  parameter int CHAR_W    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHAR_W-1:0]            chardata,
  input  logic                         isstring,
  input  logic                         ispattern,
  output logic                         valid,
  output logic                         match,
  output logic [$clog2(STR_DEPTH)-1:0] match_index,
  output logic                         busy
);

  localparam int IDX_W  = $clog2(STR_DEPTH);
  localparam int LEN_W  = $clog2(STR_DEPTH + 1);
  localparam int PLEN_W = $clog2(PAT_DEPTH + 1);
  localparam int PIDX_W = $clog2(PAT_DEPTH);

  sme_state_t                     state_reg;
  logic [STR_DEPTH-1:0][CHAR_W-1:0] str_reg;
  logic [PAT_DEPTH-1:0][CHAR_W-1:0] pat_reg;
  logic [LEN_W-1:0]               strlen_reg;
  logic [LEN_W-1:0]               pos_reg;
  logic [PLEN_W-1:0]              patlen_reg;
  logic                           anchor_start_reg;
  logic                           anchor_end_reg;
  logic                           dollar_seen_reg;
  logic                           dollar_stored_reg;
  logic                           prev_str_reg;
  logic                           prev_pat_reg;

  logic              str_act;
  logic              pat_act;
  logic              pat_first;
  logic [PLEN_W-1:0] pat_base;
  logic              caret_lead;
  logic              is_dollar;
  logic              str_we;
  logic [IDX_W-1:0]  str_waddr;
  logic              pat_we;
  logic [PIDX_W-1:0] pat_waddr;
  logic              has_cand;
  logic [LEN_W-1:0]  last_pos;
  logic              hit;

  always_comb begin
    str_act    = isstring && !busy;
    pat_act    = ispattern && !isstring && !busy;
    pat_first  = !prev_pat_reg;
    pat_base   = pat_first ? '0 : patlen_reg;
    caret_lead = pat_first && (chardata == CHAR_W'(CH_CARET));
    is_dollar  = (chardata == CHAR_W'(CH_DOLLAR));
    str_we     = str_act && (!prev_str_reg || (strlen_reg < LEN_W'(STR_DEPTH)));
    str_waddr  = prev_str_reg ? strlen_reg[IDX_W-1:0] : '0;
    pat_we     = pat_act && !caret_lead && (pat_base < PLEN_W'(PAT_DEPTH));
    pat_waddr  = pat_base[PIDX_W-1:0];
    has_cand   = (patlen_reg != '0) && (LEN_W'(patlen_reg) <= strlen_reg);
    last_pos   = strlen_reg - LEN_W'(patlen_reg);
  end

  // Character storage needs no reset: lengths alone define what is valid.
  always_ff @(posedge clk) begin
    if (str_we) str_reg[str_waddr] <= chardata;
    if (pat_we) pat_reg[pat_waddr] <= chardata;
  end

  sme_window_cmp #(
    .STR_DEPTH(STR_DEPTH),
    .PAT_DEPTH(PAT_DEPTH),
    .CHAR_W   (CHAR_W)
  ) u_cmp (
    .str         (str_reg),
    .strlen      (strlen_reg),
    .pat         (pat_reg),
    .patlen      (patlen_reg),
    .anchor_start(anchor_start_reg),
    .anchor_end  (anchor_end_reg),
    .pos         (pos_reg),
    .hit         (hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg         <= IDLE;
      strlen_reg        <= '0;
      patlen_reg        <= '0;
      pos_reg           <= '0;
      anchor_start_reg  <= 1'b0;
      anchor_end_reg    <= 1'b0;
      dollar_seen_reg   <= 1'b0;
      dollar_stored_reg <= 1'b0;
      prev_str_reg      <= 1'b0;
      prev_pat_reg      <= 1'b0;
      valid             <= 1'b0;
      match             <= 1'b0;
      match_index       <= '0;
      busy              <= 1'b0;
    end else begin
      valid        <= 1'b0;
      prev_str_reg <= str_act;
      prev_pat_reg <= pat_act;
      case (state_reg)
        SEARCH: begin
          if (has_cand && hit) begin
            match       <= 1'b1;
            match_index <= pos_reg[IDX_W-1:0];
            valid       <= 1'b1;
            state_reg   <= DONE;
          end else if (!has_cand || (pos_reg == last_pos)) begin
            match       <= 1'b0;
            match_index <= '0;
            valid       <= 1'b1;
            state_reg   <= DONE;
          end else begin
            pos_reg <= pos_reg + LEN_W'(1);
          end
        end
        DONE: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          if (str_act) begin
            state_reg <= LOAD_STR;
            if (!prev_str_reg) strlen_reg <= LEN_W'(1);
            else if (str_we)   strlen_reg <= strlen_reg + LEN_W'(1);
          end else if (pat_act) begin
            state_reg <= LOAD_PAT;
            if (pat_first) begin
              anchor_start_reg <= 1'b0;
              anchor_end_reg   <= 1'b0;
            end
            if (caret_lead) anchor_start_reg <= 1'b1;
            patlen_reg <= pat_we ? pat_base + PLEN_W'(1) : pat_base;
            // A trailing '$' is only known once ispattern falls, so it is
            // provisionally stored and withdrawn at that point.
            dollar_seen_reg   <= is_dollar;
            dollar_stored_reg <= pat_we && is_dollar;
          end else if (state_reg == LOAD_PAT) begin
            anchor_end_reg <= dollar_seen_reg;
            if (dollar_stored_reg) patlen_reg <= patlen_reg - PLEN_W'(1);
            pos_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= SEARCH;
          end else begin
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_string_match_engine.sv
// Self-checking bench: expected results are queued when a pattern is issued
// and compared against the DUT when valid pulses.
module tb_string_match_engine;

  localparam int STR_D = 32;
  localparam int PAT_D = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] chardata = '0;
  logic       isstring = 1'b0;
  logic       ispattern = 1'b0;
  logic       valid;
  logic       match;
  logic [4:0] match_index;
  logic       busy;

  typedef struct {
    bit m;
    int idx;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  string_match_engine #(.STR_DEPTH(STR_D), .PAT_DEPTH(PAT_D), .CHAR_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .chardata   (chardata),
    .isstring   (isstring),
    .ispattern  (ispattern),
    .valid      (valid),
    .match      (match),
    .match_index(match_index),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input bit m, input int idx, input int lat);
    exp_t e;
    e.m = m; e.idx = idx; e.lat = lat;
    sb.push_back(e);
  endtask

  // Reference search over the bench's own copy of the text.
  function automatic void model(input string s_in, input string p, output bit m,
                                output int idx, output int lat);
    string s;
    string lit;
    int    sl, ll, st, en;
    bit    as, ae, ok;
    s  = (s_in.len() > STR_D) ? s_in.substr(0, STR_D - 1) : s_in;
    sl = s.len();
    st = 0; en = p.len(); as = 0; ae = 0;
    if (en > 0 && p[0] == 8'h5E) begin as = 1; st = 1; end
    if (en > st && p[en-1] == 8'h24) begin ae = 1; en = en - 1; end
    lit = (en > st) ? p.substr(st, en - 1) : "";
    if (lit.len() > PAT_D) lit = lit.substr(0, PAT_D - 1);
    ll = lit.len();
    m = 0; idx = 0; lat = 1;
    if (ll == 0 || ll > sl) return;
    for (int q = 0; q <= sl - ll; q++) begin
      ok = 1;
      for (int i = 0; i < ll; i++)
        if (lit[i] != 8'h2E && s[q+i] != lit[i]) ok = 0;
      if (as && q != 0 && s[q-1] != 8'h20) ok = 0;
      if (ae && q + ll != sl && s[q+ll] != 8'h20) ok = 0;
      lat = q + 1;
      if (ok) begin m = 1; idx = q; return; end
    end
  endfunction

  task automatic push_model(input string s, input string p);
    bit m; int idx, lat;
    model(s, p, m, idx, lat);
    push_exp(m, idx, lat);
  endtask

  task automatic send_string(input string s);
    isstring = 0; ispattern = 0; tick();
    for (int i = 0; i < s.len(); i++) begin
      isstring = 1; chardata = s[i]; tick();
    end
    isstring = 0;
  endtask

  task automatic send_pattern(input string p);
    for (int i = 0; i < p.len(); i++) begin
      ispattern = 1; chardata = p[i]; tick();
    end
  endtask

  // Drops ispattern, waits for valid and checks it against the scoreboard head.
  task automatic run_search(input string name);
    exp_t e;
    int   cyc;
    bit   got;
    ispattern = 0;
    tick();
    got = 0;
    cyc = 0;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (valid === 1'b1) begin got = 1; cyc = c; break; end
    end
    e = sb.pop_front();
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL %s timeout: valid not seen within 100 cycles, required after %0d", name, e.lat);
      return;
    end
    $display("[TB] %s: match=%0d idx=%0d latency=%0d (expected %0d/%0d/%0d)",
             name, match, match_index, cyc, e.m, e.idx, e.lat);
    if (cyc != e.lat) begin
      fails++; $display("FAIL %s latency: got %0d required %0d", name, cyc, e.lat);
    end
    tests++;
    if (match !== e.m) begin
      fails++; $display("FAIL %s match: got %0d required %0d", name, match, e.m);
    end
    tests++;
    if (match_index !== 5'(e.idx)) begin
      fails++; $display("FAIL %s match_index: got %0d required %0d", name, match_index, e.idx);
    end
    tick();
    tests++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL %s pulse_end: valid=%0b busy=%0b required 0/0", name, valid, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1; tick(); tick();
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset valid: got %0b required 0", valid); end
    tests++; if (match !== 1'b0) begin fails++; $display("FAIL reset match: got %0b required 0", match); end
    tests++; if (match_index !== 5'd0) begin fails++; $display("FAIL reset match_index: got %0d required 0", match_index); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset busy: got %0b required 0", busy); end
    reset = 0; tick();
  endtask

  task automatic test_basic();
    send_string("hello world");
    push_exp(1, 6, 7); send_pattern("wor"); run_search("basic_wor");
  endtask

  task automatic test_anchors();
    push_exp(1, 6, 7); send_pattern("^wor");  run_search("anchor_start");
    push_exp(0, 0, 9); send_pattern("^wor$"); run_search("anchor_both");
  endtask

  task automatic test_wildcard_len();
    send_string("abc");
    push_exp(1, 0, 1); send_pattern("a.c$"); run_search("wildcard_end");
    push_exp(0, 0, 1); send_pattern("abcd"); run_search("pat_too_long");
  endtask

  task automatic test_overflow();
    string s, c;
    s = ""; c = " ";
    for (int i = 0; i < 40; i++) begin
      c.putc(0, byte'(65 + i));
      s = {s, c};
    end
    send_string(s);
    push_exp(1, 28, 29); send_pattern(s.substr(28, 31)); run_search("overflow_tail");
    push_exp(0, 0, 29);  send_pattern(s.substr(32, 35)); run_search("overflow_dropped");
  endtask

  task automatic test_reset_search();
    bit seen;
    send_string("hello world");
    push_exp(1, 2, 3); send_pattern("llo"); run_search("pre_reset");
    send_pattern("zzz");
    ispattern = 0; tick(); tick(); tick();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_search busy: got %0b required 1", busy); end
    #2 reset = 1;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL async_reset busy: got %0b required 0", busy); end
    tests++; if (match !== 1'b0) begin fails++; $display("FAIL async_reset match: got %0b required 0", match); end
    tests++; if (match_index !== 5'd0) begin fails++; $display("FAIL async_reset match_index: got %0d required 0", match_index); end
    tick(); reset = 0;
    seen = 0;
    repeat (15) begin tick(); if (valid === 1'b1) seen = 1; end
    tests++; if (seen) begin fails++; $display("FAIL aborted_search valid: got 1 required 0"); end
    send_string("abc");
    push_exp(1, 1, 2); send_pattern("bc"); run_search("post_reset");
  endtask

  task automatic test_busy_ignore();
    send_string("hello world");
    push_exp(1, 4, 5);
    send_pattern("o w");
    fork
      run_search("busy_ignore");
      begin
        tick(); tick();
        isstring = 1; chardata = 8'h58; tick(); tick();
        isstring = 0;
      end
    join
    push_exp(1, 6, 7); send_pattern("world$"); run_search("string_kept");
  endtask

  task automatic test_back_to_back();
    string s;
    string pats[12];
    s = "the cat sat on the mat";
    pats = '{"at", "^the", "the$", "mat$", "^.at", "c.t", "xyz", "s.t o",
             "^", "a", "t$", "the cat sat"};
    send_string(s);
    foreach (pats[i]) begin
      push_model(s, pats[i]); send_pattern(pats[i]); run_search(pats[i]);
    end
  endtask

  task automatic test_random();
    string ab, pb, s, p;
    int n, j;
    ab = "ab "; pb = "ab.";
    for (int t = 0; t < 6; t++) begin
      s = "";
      n = $urandom_range(12, 1);
      for (int k = 0; k < n; k++) begin j = $urandom_range(2, 0); s = {s, ab.substr(j, j)}; end
      send_string(s);
      for (int u = 0; u < 3; u++) begin
        p = ($urandom_range(1, 0) == 1) ? "^" : "";
        n = $urandom_range(4, 1);
        for (int k = 0; k < n; k++) begin j = $urandom_range(2, 0); p = {p, pb.substr(j, j)}; end
        if ($urandom_range(1, 0) == 1) p = {p, "$"};
        push_model(s, p); send_pattern(p); run_search({"rand '", s, "' '", p, "'"});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_anchors();
    test_wildcard_len();
    test_overflow();
    test_reset_search();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
